// File: rtl/fetch_controller.sv
// Program counter and instruction-fetch sequencer for an asynchronous-read program memory.
// Registers the fetched word into an instruction register and hands it to decode over valid/ready.
module fetch_controller #(
   parameter int                P_SIZE   = 6,
   parameter int                I_SIZE   = 24,
   parameter logic [P_SIZE-1:0] RESET_PC = {P_SIZE{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt_req,
   output logic [P_SIZE-1:0] pc_address,
   input  logic [I_SIZE-1:0] mem_instruction,
   output logic [I_SIZE-1:0] instr,
   output logic [P_SIZE-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch_taken,
   input  logic              branch_rel,
   input  logic [P_SIZE-1:0] branch_offset,
   output logic              running,
   output logic              halted,
   output logic              wrapped
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [P_SIZE-1:0] PC_ONE = {{(P_SIZE-1){1'b0}}, 1'b1};

   state_t              state_r;
   state_t              state_nxt_s;
   logic [P_SIZE-1:0]   pc_r;
   logic [P_SIZE-1:0]   pc_nxt_s;
   logic [I_SIZE-1:0]   instr_r;
   logic [I_SIZE-1:0]   instr_nxt_s;
   logic [P_SIZE-1:0]   instr_pc_r;
   logic [P_SIZE-1:0]   instr_pc_nxt_s;
   logic                instr_valid_r;
   logic                instr_valid_nxt_s;
   logic                wrapped_r;
   logic                wrapped_nxt_s;
   logic                running_r;
   logic                halted_r;
   logic                consume_s;
   logic                load_s;
   logic                branch_s;
   logic [P_SIZE-1:0]   target_s;

   assign consume_s = instr_valid_r && instr_ready;
   assign load_s    = (state_r == ST_RUN) && (!instr_valid_r || instr_ready);
   // Branches only take effect on an accepted instruction; IDLE never holds one.
   assign branch_s  = consume_s && branch_taken && (state_r != ST_IDLE);
   assign target_s  = branch_rel ? (instr_pc_r + branch_offset) : branch_offset;

   // Control FSM next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_RUN;
            else       state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (halt_req) state_nxt_s = ST_DRAIN;
            else          state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (!instr_valid_r || consume_s) state_nxt_s = ST_HALTED;
            else                             state_nxt_s = ST_DRAIN;
         end
         ST_HALTED: begin
            if (start) state_nxt_s = ST_RUN;
            else       state_nxt_s = ST_HALTED;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // PC / instruction register next-value selection: branch beats fetch beats plain consume.
   always_comb begin
      pc_nxt_s          = pc_r;
      instr_nxt_s       = instr_r;
      instr_pc_nxt_s    = instr_pc_r;
      instr_valid_nxt_s = instr_valid_r;
      wrapped_nxt_s     = wrapped_r;
      if (branch_s) begin
         pc_nxt_s          = target_s;
         instr_valid_nxt_s = 1'b0;
      end else if (load_s) begin
         instr_nxt_s       = mem_instruction;
         instr_pc_nxt_s    = pc_r;
         instr_valid_nxt_s = 1'b1;
         pc_nxt_s          = pc_r + PC_ONE;
         wrapped_nxt_s     = wrapped_r | (&pc_r);
      end else if (consume_s) begin
         instr_valid_nxt_s = 1'b0;
      end else begin
         instr_valid_nxt_s = instr_valid_r;
      end
   end

   // State and datapath registers; status flags are decoded from the next state so they track state_r.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         pc_r          <= RESET_PC;
         instr_r       <= {I_SIZE{1'b0}};
         instr_pc_r    <= {P_SIZE{1'b0}};
         instr_valid_r <= 1'b0;
         wrapped_r     <= 1'b0;
         running_r     <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         instr_r       <= instr_nxt_s;
         instr_pc_r    <= instr_pc_nxt_s;
         instr_valid_r <= instr_valid_nxt_s;
         wrapped_r     <= wrapped_nxt_s;
         running_r     <= (state_nxt_s == ST_RUN);
         halted_r      <= (state_nxt_s == ST_HALTED);
      end
   end

   assign pc_address  = pc_r;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = instr_valid_r;
   assign running     = running_r;
   assign halted      = halted_r;
   assign wrapped     = wrapped_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a model memory returns a word derived from its address,
// and every accepted instruction is checked against a queue of expected fetch addresses.
module tb_fetch_controller;

   logic        clk;
   logic        reset;
   logic        start;
   logic        halt_req;
   logic [5:0]  pc_address;
   logic [23:0] mem_instruction;
   logic [23:0] instr;
   logic [5:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch_taken;
   logic        branch_rel;
   logic [5:0]  branch_offset;
   logic        running;
   logic        halted;
   logic        wrapped;

   int          n_cmp;
   int          n_err;
   logic [5:0]  sb_q[$];

   fetch_controller #(.P_SIZE(6), .I_SIZE(24), .RESET_PC(6'd0)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .halt_req        (halt_req),
      .pc_address      (pc_address),
      .mem_instruction (mem_instruction),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .branch_taken    (branch_taken),
      .branch_rel      (branch_rel),
      .branch_offset   (branch_offset),
      .running         (running),
      .halted          (halted),
      .wrapped         (wrapped)
   );

   function automatic logic [23:0] mem_word(input logic [5:0] a);
      return {a, 12'h5A3, a};
   endfunction

   assign mem_instruction = mem_word(pc_address);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the instruction accepted at the coming edge against the scoreboard, then advance one cycle.
   task automatic cyc();
      logic [5:0] e;
      if (instr_valid && instr_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("sb_instr_pc", 32'(instr_pc), 32'(e));
            chk("sb_instr", 32'(instr), 32'(mem_word(e)));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      start = 1'b0;
      halt_req = 1'b0;
      instr_ready = 1'b0;
      branch_taken = 1'b0;
      branch_rel = 1'b0;
      branch_offset = 6'd0;
      cyc();
      cyc();
      chk("rst_pc", 32'(pc_address), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_wrapped", 32'(wrapped), 32'd0);
      reset = 1'b0;

      // Sequential fetch from reset, first valid two edges after start.
      for (int k = 0; k < 4; k++) sb_q.push_back(6'(k));
      instr_ready = 1'b1;
      start = 1'b1;
      cyc();
      chk("start_running", 32'(running), 32'd1);
      chk("start_valid_e1", 32'(instr_valid), 32'd0);
      chk("start_pc_e1", 32'(pc_address), 32'd0);
      start = 1'b0;
      cyc();
      chk("first_valid_e2", 32'(instr_valid), 32'd1);
      chk("first_instr_pc", 32'(instr_pc), 32'd0);
      chk("first_pc", 32'(pc_address), 32'd1);
      cyc();
      cyc();
      cyc();
      chk("at3_instr_pc", 32'(instr_pc), 32'd3);

      // Absolute branch to 20 while consuming 3.
      branch_taken = 1'b1;
      branch_rel = 1'b0;
      branch_offset = 6'd20;
      cyc();
      branch_taken = 1'b0;
      chk("abs_bubble_valid", 32'(instr_valid), 32'd0);
      chk("abs_target_pc", 32'(pc_address), 32'd20);
      sb_q.push_back(6'd20);
      sb_q.push_back(6'd21);
      cyc();
      chk("abs_first", 32'(instr_pc), 32'd20);
      cyc();
      chk("abs_second", 32'(instr_pc), 32'd21);

      // Branch to 1, then relative -2 from 1 lands on 63 and the next increment wraps.
      branch_taken = 1'b1;
      branch_offset = 6'd1;
      cyc();
      branch_taken = 1'b0;
      sb_q.push_back(6'd1);
      cyc();
      chk("to1_instr_pc", 32'(instr_pc), 32'd1);
      branch_taken = 1'b1;
      branch_rel = 1'b1;
      branch_offset = 6'h3E;
      cyc();
      branch_taken = 1'b0;
      branch_rel = 1'b0;
      chk("rel_target_pc", 32'(pc_address), 32'd63);
      chk("rel_bubble_valid", 32'(instr_valid), 32'd0);
      chk("wrapped_before", 32'(wrapped), 32'd0);
      sb_q.push_back(6'd63);
      for (int k = 0; k < 6; k++) sb_q.push_back(6'(k));
      cyc();
      chk("rel_instr_pc", 32'(instr_pc), 32'd63);
      chk("wrapped_after", 32'(wrapped), 32'd1);
      chk("wrap_pc", 32'(pc_address), 32'd0);
      cyc();
      chk("post_wrap_instr_pc", 32'(instr_pc), 32'd0);
      for (int k = 0; k < 5; k++) cyc();

      // Backpressure hold at instr_pc=5.
      instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stall_instr_pc", 32'(instr_pc), 32'd5);
         chk("stall_pc", 32'(pc_address), 32'd6);
         chk("stall_valid", 32'(instr_valid), 32'd1);
      end
      chk("stall_instr", 32'(instr), 32'(mem_word(6'd5)));
      instr_ready = 1'b1;
      sb_q.push_back(6'd6);
      sb_q.push_back(6'd7);
      cyc();
      chk("release_instr_pc", 32'(instr_pc), 32'd6);
      cyc();

      // Halt while decode stalls, drain, then resume without skipping.
      instr_ready = 1'b0;
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      chk("drain_running", 32'(running), 32'd0);
      chk("drain_halted", 32'(halted), 32'd0);
      chk("drain_pc", 32'(pc_address), 32'd8);
      chk("drain_instr_pc", 32'(instr_pc), 32'd7);
      cyc();
      chk("drain_hold_pc", 32'(pc_address), 32'd8);
      chk("drain_hold_valid", 32'(instr_valid), 32'd1);
      instr_ready = 1'b1;
      cyc();
      chk("halted_flag", 32'(halted), 32'd1);
      chk("halted_valid", 32'(instr_valid), 32'd0);
      chk("halted_pc", 32'(pc_address), 32'd8);
      cyc();
      chk("halted_hold_pc", 32'(pc_address), 32'd8);
      chk("halted_hold_flag", 32'(halted), 32'd1);
      for (int k = 8; k < 11; k++) sb_q.push_back(6'(k));
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("resume_running", 32'(running), 32'd1);
      chk("resume_halted", 32'(halted), 32'd0);
      cyc();
      chk("resume_instr_pc", 32'(instr_pc), 32'd8);
      cyc();
      cyc();
      cyc();
      chk("pre_reset_pc", 32'(pc_address), 32'd12);
      chk("pre_reset_valid", 32'(instr_valid), 32'd1);

      // Reset mid-run overrides start/halt_req.
      instr_ready = 1'b0;
      reset = 1'b1;
      start = 1'b1;
      halt_req = 1'b1;
      cyc();
      reset = 1'b0;
      start = 1'b0;
      halt_req = 1'b0;
      chk("mid_rst_pc", 32'(pc_address), 32'd0);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_wrapped", 32'(wrapped), 32'd0);
      chk("mid_rst_running", 32'(running), 32'd0);
      chk("mid_rst_instr_pc", 32'(instr_pc), 32'd0);
      cyc();
      chk("mid_rst_idle_pc", 32'(pc_address), 32'd0);
      chk("mid_rst_idle_valid", 32'(instr_valid), 32'd0);

      // Restart after reset fetches from address 0 again.
      sb_q.push_back(6'd0);
      instr_ready = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      chk("sb_leftover", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
